// File: rtl/tristate_grant_seq_pkg.sv
// rtl/tristate_grant_seq_pkg.sv - shared types and constants for the tri-state grant sequencer
package tristate_grant_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    localparam int GUARD_DEFAULT = 1;
    localparam int CNT_W         = 4;

    // Index width for n sources, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tristate_grant_seq_rr_pick.sv
// rtl/tristate_grant_seq_rr_pick.sv - combinational round-robin search starting after ptr
module rr_pick
    import tristate_grant_seq_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tristate_grant_seq.sv
// rtl/tristate_grant_seq.sv - request-aware round-robin tri-state enable sequencer with guard gaps
module tristate_grant_seq
    import tristate_grant_seq_pkg::*;
#(
    parameter int N     = 3,
    parameter int GUARD = GUARD_DEFAULT,
    localparam int IW   = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tick,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  en,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;

    state_t            state, state_n;
    logic [IW-1:0]     sel, sel_n;
    logic [IW-1:0]     ptr, ptr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [N-1:0]      en_n;
    logic              valid_n;
    logic [IW-1:0]     idx_n;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        return N'(1) << i;
    endfunction

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        en_n    = en;
        valid_n = gnt_valid;
        idx_n   = gnt_idx;
        case (state)
            ST_IDLE: begin
                en_n    = '0;
                valid_n = 1'b0;
                if (tick && pick_found) begin
                    sel_n = pick_idx;
                    if (GUARD > 0) begin
                        state_n = ST_GUARD;
                        cnt_n   = GUARD_LOAD;
                    end else begin
                        state_n = ST_GRANT;
                        en_n    = onehot(pick_idx);
                        valid_n = 1'b1;
                        idx_n   = pick_idx;
                        ptr_n   = pick_idx;
                    end
                end
            end
            ST_GUARD: begin
                en_n    = '0;
                valid_n = 1'b0;
                // A withdrawn request cancels the pending grant; ticks are ignored here.
                if (!req[sel]) begin
                    state_n = ST_IDLE;
                end else if (cnt == '0) begin
                    state_n = ST_GRANT;
                    en_n    = onehot(sel);
                    valid_n = 1'b1;
                    idx_n   = sel;
                    ptr_n   = sel;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_GRANT: begin
                if (tick) begin
                    en_n    = '0;
                    valid_n = 1'b0;
                    if (pick_found) begin
                        sel_n = pick_idx;
                        if (GUARD > 0) begin
                            state_n = ST_GUARD;
                            cnt_n   = GUARD_LOAD;
                        end else begin
                            en_n    = onehot(pick_idx);
                            valid_n = 1'b1;
                            idx_n   = pick_idx;
                            ptr_n   = pick_idx;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (!req[sel]) begin
                    en_n    = '0;
                    valid_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                en_n    = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            sel       <= '0;
            ptr       <= IW'(N - 1);
            cnt       <= '0;
            en        <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            en        <= en_n;
            gnt_valid <= valid_n;
            gnt_idx   <= idx_n;
        end
    end

endmodule
